encoder83_debounce: RTL and testbench
=====================================

Name: encoder83_debounce

Overview:
- 8-to-3 line encoder: the return path for the board's 3-to-8 select decoder.
- Takes 8 asynchronous key/strobe lines, either one-hot or one-cold selectable by `i_opt`.
- Synchronises, priority-encodes and debounces them, then presents a stable 3-bit code with a level-valid flag and a req/ack event handshake.
- Sits between front-panel input pins and control logic.

Parameters:
- `DEBOUNCE_CYCLES`, 20000, consecutive clocks a candidate must stay unchanged to be accepted; must be >= 2.
- `CNT_W`, 16, debounce counter width; must hold `DEBOUNCE_CYCLES-1`.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst_n`  in  1  reset, synchronous, active-low.
- `i_opt`  in  1  line polarity: 1 = active-high (one-hot), 0 = active-low (one-cold). Quasi-static.
- `i_lines`  in  8  asynchronous input lines.
- `i_ack`  in  1  consumer acknowledge of `o_req`.
- `o_code`  out  3  accepted code, index of the winning line.
- `o_valid`  out  1  high while an accepted key is held.
- `o_multi`  out  1  accepted pattern had more than one active line.
- `o_req`  out  1  new-press event pending; held until acknowledged.
- `o_overrun`  out  1  one-cycle pulse: new press accepted while `o_req` was still pending.

Behaviour:
- **Reset** (`i_rst_n`=0 at a rising edge):
  - `o_code`=0, `o_valid`=0, `o_multi`=0, `o_req`=0, `o_overrun`=0.
  - FSM to `S_IDLE`, counter 0.
  - Sync flops load `{8{~i_opt}}` (all lines inactive).
  - Reset mid-operation discards any pending `o_req` without ack.
- **Synchroniser:** 2-flop per line.
  - `act = i_opt ? sync2 : ~sync2`.
- **Candidate (combinational from `act`):**
  - `any` = |act.
  - `multi` = more than one bit set.
  - `code` = lowest set index; bit 0 has highest priority; code 0 when none set.
- **FSM states:** `S_IDLE`, `S_DB`, `S_HELD`, `S_REL`.
  - `S_IDLE`: if `any`, go to `S_DB`, cnt=0, `last`={code,multi}.
  - `S_DB`:
    - Candidate differs from `last`: cnt=0, `last` updated; go to `S_IDLE` if !`any`.
    - Else if cnt==`DEBOUNCE_CYCLES`-1: go to `S_HELD`; latch `o_code`/`o_multi`; `o_valid`=1; set `o_req`.
    - Else cnt++.
  - `S_HELD`: candidate (any,code,multi) differs from latched value: go to `S_REL`, cnt=0, `last`=candidate.
  - `S_REL`:
    - Candidate equals latched value: back to `S_HELD`; no new event.
    - Candidate differs from `last`: cnt=0, `last` updated.
    - cnt==`DEBOUNCE_CYCLES`-1: `o_valid`=0. Go to `S_IDLE` if !`any`, else to `S_DB` with cnt=0.
  - `o_code`/`o_multi` hold their last accepted values after release.
- **Latency:** with N=`DEBOUNCE_CYCLES`, `o_valid`/`o_req` rise on the (N+3)th rising edge, counting the edge that first samples the changed line as the 1st. Release has the same latency.
- **Handshake:**
  - `o_req` clears on an edge where `o_req`=1 and `i_ack`=1.
  - `i_ack` while `o_req`=0 is ignored.
  - New acceptance in the same cycle as ack: `o_req` stays 1 with the new code, no overrun.
  - New acceptance with `o_req`=1 and no ack: `o_code` overwritten, `o_req` stays 1, `o_overrun` pulses for 1 cycle.
- **Glitches:** any candidate change shorter than N cycles never produces `o_req`.
- **`i_opt` toggles:** treated as an ordinary candidate change; debounce restarts.
- **Counter:** saturates at N-1 (no wrap).

Decomposition:
- Package `encoder83_pkg`:
  - State enum.
  - `OPT_ACT_HIGH`/`OPT_ACT_LOW` constants.
  - Function `prio_enc8` (returns code, any, multi).
- One sub-module: `line_sync` (parameterised width, 2-flop synchroniser with reset value input).

Test Plan (N=4):
- Reset with `i_opt`=0, `i_lines`=8'hFF → all outputs 0, no `o_req` for 20 cycles.
- `i_opt`=0, `i_lines`=8'hF7 held → `o_code`=3, `o_valid`=1, `o_req`=1 on 7th edge. `i_ack` one cycle → `o_req`=0, `o_valid` stays 1.
- `i_opt`=1, `i_lines`=8'h24 → `o_code`=2, `o_multi`=1. Then release to 8'h00 → `o_valid`=0 on 7th edge after release.
- `i_opt`=1, 8'h80 pulse lasting 3 cycles → no `o_req`, `o_valid` stays 0. Bounce 8'h80/00/80 every 2 cycles then hold → single `o_req` with `o_code`=7.
- Accept 8'h01 without ack, release, accept 8'h10 → `o_code`=4, `o_overrun` 1-cycle pulse, `o_req` stays 1. Repeat with ack on the acceptance edge → no overrun.
- Assert `i_rst_n`=0 while in `S_HELD` with `o_req`=1 → next edge all outputs 0. Line still held after reset → re-accepted after N+3 edges.

Source files
------------

// File: rtl/encoder83_pkg.sv
// Shared types and helpers for the 8-to-3 debounced encoder.
package encoder83_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DB,
        S_HELD,
        S_REL
    } state_t;

    localparam logic OPT_ACT_HIGH = 1'b1;
    localparam logic OPT_ACT_LOW  = 1'b0;

    typedef struct packed {
        logic       any;
        logic [2:0] code;
        logic       multi;
    } cand_t;

    // Lowest set index wins; act & (act-1) clears the lowest bit, so nonzero means two or more.
    function automatic cand_t prio_enc8(input logic [7:0] act);
        cand_t c;
        c.any   = |act;
        c.multi = (act & (act - 8'd1)) != 8'd0;
        c.code  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (act[i]) begin
                c.code = 3'(i);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/encoder83_debounce_line_sync.sv
// Two-flop synchroniser for a bus of asynchronous lines; reset loads a caller-chosen idle pattern.
module line_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] rst_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_reg;
    logic [W-1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_reg <= rst_val;
            sync_reg <= rst_val;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/encoder83_debounce.sv
// Synchronise, priority-encode and debounce eight key lines; present a stable code with req/ack events.
module encoder83_debounce
    import encoder83_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter int CNT_W           = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_opt,
    input  logic [7:0] i_lines,
    input  logic       i_ack,
    output logic [2:0] o_code,
    output logic       o_valid,
    output logic       o_multi,
    output logic       o_req,
    output logic       o_overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0] sync2;
    logic [7:0] act;
    cand_t      cand;
    cand_t      latched;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    cand_t            last_reg, last_next;
    logic [2:0]       code_reg, code_next;
    logic             multi_reg, multi_next;
    logic             valid_reg, valid_next;
    logic             req_reg, req_next;
    logic             overrun_reg, overrun_next;
    logic             accept;

    line_sync #(.W(8)) u_sync (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .rst_val ({8{~i_opt}}),
        .d       (i_lines),
        .q       (sync2)
    );

    assign act     = (i_opt == OPT_ACT_HIGH) ? sync2 : ~sync2;
    assign cand    = prio_enc8(act);
    assign latched = {1'b1, code_reg, multi_reg};

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        last_next  = last_reg;
        code_next  = code_reg;
        multi_next = multi_reg;
        valid_next = valid_reg;
        accept     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (cand.any) begin
                    state_next = S_DB;
                    cnt_next   = '0;
                    last_next  = cand;
                end
            end
            S_DB: begin
                if (cand != last_reg) begin
                    cnt_next  = '0;
                    last_next = cand;
                    if (!cand.any) begin
                        state_next = S_IDLE;
                    end
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = S_HELD;
                    code_next  = cand.code;
                    multi_next = cand.multi;
                    valid_next = 1'b1;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_HELD: begin
                if (cand != latched) begin
                    state_next = S_REL;
                    cnt_next   = '0;
                    last_next  = cand;
                end
            end
            S_REL: begin
                // Returning to the accepted key before the window ends is a bounce, not a new press.
                if (cand == latched) begin
                    state_next = S_HELD;
                end else if (cand != last_reg) begin
                    cnt_next  = '0;
                    last_next = cand;
                end else if (cnt_reg == CNT_MAX) begin
                    valid_next = 1'b0;
                    cnt_next   = '0;
                    state_next = cand.any ? S_DB : S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // An acceptance always leaves an event pending; it only overruns if the old one was neither acked nor consumed.
    always_comb begin
        req_next     = req_reg;
        overrun_next = 1'b0;
        if (accept) begin
            req_next     = 1'b1;
            overrun_next = req_reg & ~i_ack;
        end else if (req_reg && i_ack) begin
            req_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            last_reg    <= '0;
            code_reg    <= 3'd0;
            multi_reg   <= 1'b0;
            valid_reg   <= 1'b0;
            req_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            last_reg    <= last_next;
            code_reg    <= code_next;
            multi_reg   <= multi_next;
            valid_reg   <= valid_next;
            req_reg     <= req_next;
            overrun_reg <= overrun_next;
        end
    end

    assign o_code    = code_reg;
    assign o_valid   = valid_reg;
    assign o_multi   = multi_reg;
    assign o_req     = req_reg;
    assign o_overrun = overrun_reg;

endmodule

// File: tb/tb_encoder83_debounce.sv
// Bench for encoder83_debounce: run-length reference model plus directed latency and handshake checks.
module tb_encoder83_debounce;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       opt;
    logic [7:0] lines;
    logic       ack;
    logic [2:0] o_code;
    logic       o_valid;
    logic       o_multi;
    logic       o_req;
    logic       o_overrun;

    always #5 clk = ~clk;

    encoder83_debounce #(
        .DEBOUNCE_CYCLES (N),
        .CNT_W           (4)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_opt     (opt),
        .i_lines   (lines),
        .i_ack     (ack),
        .o_code    (o_code),
        .o_valid   (o_valid),
        .o_multi   (o_multi),
        .o_req     (o_req),
        .o_overrun (o_overrun)
    );

    typedef struct packed {
        logic       any;
        logic [2:0] code;
        logic       multi;
    } mc_t;

    // Candidate by counting active lines and remembering the lowest one.
    function automatic mc_t ref_cand(input logic [7:0] raw, input logic pol);
        logic [7:0] a;
        int         n;
        mc_t        r;
        a = pol ? raw : ~raw;
        n = 0;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (a[i]) begin
                n++;
                r.code = 3'(i);
            end
        end
        r.any   = (n > 0);
        r.multi = (n > 1);
        return r;
    endfunction

    // Reference model: a candidate is accepted/released once it has been seen N+1 times in a row
    // (counting from the later of its first sighting and the last release).
    logic [7:0] m_d1, m_d2;
    mc_t        m_prev;
    int         m_run_start, m_drop, cyc;
    logic [2:0] m_code;
    logic       m_valid, m_multi, m_req, m_over;

    initial begin : model
        mc_t  c;
        int   s;
        logic acc;
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_d1 = {8{~opt}};
                m_d2 = {8{~opt}};
                m_prev = '0;
                m_run_start = cyc;
                m_drop = cyc;
                m_code = 3'd0; m_valid = 1'b0; m_multi = 1'b0; m_req = 1'b0; m_over = 1'b0;
            end else begin
                c = ref_cand(m_d2, opt);
                m_d2 = m_d1;
                m_d1 = lines;
                if (c != m_prev) begin
                    m_prev = c;
                    m_run_start = cyc;
                end
                acc = 1'b0;
                m_over = 1'b0;
                if (!m_valid) begin
                    s = (m_run_start > m_drop) ? m_run_start : m_drop;
                    if (c.any && (cyc - s == N)) acc = 1'b1;
                end else if ((!c.any || c.code != m_code || c.multi != m_multi) && (cyc - m_run_start == N)) begin
                    m_valid = 1'b0;
                    m_drop = cyc;
                end
                if (acc) begin
                    m_over = m_req && !ack;
                    m_req = 1'b1;
                    m_valid = 1'b1;
                    m_code = c.code;
                    m_multi = c.multi;
                end else if (m_req && ack) begin
                    m_req = 1'b0;
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;
    int rises, ovrs;
    logic req_prev = 1'b0;

    task automatic step();
        @(negedge clk);
        checks++;
        if ({o_code, o_valid, o_multi, o_req, o_overrun} !== {m_code, m_valid, m_multi, m_req, m_over}) begin
            failures++;
            $display("FAIL model_cmp cyc=%0d got code=%0d valid=%b multi=%b req=%b ovr=%b expected code=%0d valid=%b multi=%b req=%b ovr=%b",
                     cyc, o_code, o_valid, o_multi, o_req, o_overrun, m_code, m_valid, m_multi, m_req, m_over);
        end
        if (o_req && !req_prev) rises++;
        if (o_overrun) ovrs++;
        req_prev = o_req;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic do_reset(input logic pol);
        rst_n = 1'b0;
        opt = pol;
        lines = pol ? 8'h00 : 8'hFF;
        ack = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(3);
        rises = 0;
        ovrs = 0;
    endtask

    initial begin
        logic [7:0] a, one;
        int         dur;
        rst_n = 1'b0; opt = 1'b0; lines = 8'hFF; ack = 1'b0;
        rises = 0; ovrs = 0;

        // Idle after reset, active-low, all lines released
        do_reset(1'b0);
        run(20);
        chk("idle_req", int'(o_req), 0);
        chk("idle_valid", int'(o_valid), 0);
        chk("idle_code", int'(o_code), 0);

        // One-cold press of line 3: visible on the 7th edge
        lines = 8'hF7;
        run(6);
        chk("press3_valid_e6", int'(o_valid), 0);
        run(1);
        chk("press3_valid_e7", int'(o_valid), 1);
        chk("press3_req_e7", int'(o_req), 1);
        chk("press3_code", int'(o_code), 3);
        ack = 1'b1; run(1); ack = 1'b0;
        chk("press3_req_acked", int'(o_req), 0);
        chk("press3_valid_after_ack", int'(o_valid), 1);
        run(3);

        // One-hot multi-press 0x24, then release
        do_reset(1'b1);
        lines = 8'h24;
        run(6);
        chk("multi_valid_e6", int'(o_valid), 0);
        run(1);
        chk("multi_code", int'(o_code), 2);
        chk("multi_flag", int'(o_multi), 1);
        ack = 1'b1; run(1); ack = 1'b0;
        run(5);
        lines = 8'h00;
        run(6);
        chk("release_valid_e6", int'(o_valid), 1);
        run(1);
        chk("release_valid_e7", int'(o_valid), 0);
        chk("release_code_held", int'(o_code), 2);

        // Short glitch, then a bouncing press
        do_reset(1'b1);
        lines = 8'h80; run(3);
        lines = 8'h00; run(12);
        chk("glitch_rises", rises, 0);
        chk("glitch_valid", int'(o_valid), 0);
        for (int b = 0; b < 2; b++) begin
            lines = 8'h80; run(2);
            lines = 8'h00; run(2);
        end
        lines = 8'h80; run(12);
        chk("bounce_rises", rises, 1);
        chk("bounce_code", int'(o_code), 7);

        // Overrun: second acceptance without ack
        do_reset(1'b1);
        lines = 8'h01; run(10);
        lines = 8'h00; run(10);
        lines = 8'h10; run(10);
        chk("ovr_pulses", ovrs, 1);
        chk("ovr_code", int'(o_code), 4);
        chk("ovr_req", int'(o_req), 1);
        // Ack on the acceptance edge itself: no overrun
        lines = 8'h00; run(10);
        ovrs = 0;
        lines = 8'h01; run(6);
        ack = 1'b1; run(1); ack = 1'b0;
        chk("ackaccept_ovr", int'(o_overrun), 0);
        chk("ackaccept_req", int'(o_req), 1);
        chk("ackaccept_code", int'(o_code), 0);
        run(3);
        chk("ackaccept_pulses", ovrs, 0);

        // Reset while held with a pending event, line still pressed
        rst_n = 1'b0; run(1);
        chk("midrst_outputs", int'({o_code, o_valid, o_multi, o_req, o_overrun}), 0);
        rst_n = 1'b1;
        run(6);
        chk("reaccept_e6", int'(o_valid), 0);
        run(1);
        chk("reaccept_e7", int'(o_valid), 1);
        chk("reaccept_req", int'(o_req), 1);

        // Randomised traffic against the model
        do_reset(1'b1);
        for (int seg = 0; seg < 600; seg++) begin
            one = 8'h01;
            case ($urandom_range(0, 3))
                0: a = 8'h00;
                1: a = one << $urandom_range(0, 7);
                2: a = (one << $urandom_range(0, 7)) | (one << $urandom_range(0, 7));
                default: a = 8'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) opt = ~opt;
            lines = opt ? a : ~a;
            dur = $urandom_range(1, 10);
            for (int j = 0; j < dur; j++) begin
                ack = ($urandom_range(0, 3) == 0);
                rst_n = ($urandom_range(0, 399) != 0);
                step();
            end
        end
        rst_n = 1'b1; ack = 1'b0;
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
